// File: rtl/nano4k_flash_page_sequencer.sv
// Page-update sequencer for a single-IO SPI flash interface: optional WREN+erase,
// then WREN+page program, each followed by RDSR busy polling with a timeout.
module nano4k_flash_page_sequencer #(
    parameter int unsigned CS_GAP     = 4,
    parameter logic [23:0] POLL_LIMIT = 24'd600000
) (
    input  logic        serialClk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        doErase,
    input  logic [15:0] pageAddr,
    input  logic [8:0]  byteCount,
    input  logic [7:0]  wrByte,
    output logic        wrByteAck,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  lastStatus,
    output logic        ifEnable_n,
    output logic [7:0]  fCommand,
    output logic [23:0] fAddress,
    output logic [7:0]  fData_WR,
    input  logic [7:0]  fData_RD,
    input  logic        cmdFinished,
    input  logic        WrDataReady
);
    localparam int unsigned   GW       = (CS_GAP > 2) ? $clog2(CS_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

    typedef enum logic [2:0] {IDLE, GAP, WREN, ERASE, POLL, PP_LOAD, PROGRAM, FINISH} state_t;

    state_t        state, stateNx, afterGap, afterGapNx, afterWren, afterWrenNx;
    logic [GW-1:0] gapCnt, gapCntNx;
    logic [8:0]    count, countNx, loaded, loadedNx, sent, sentNx;
    logic [23:0]   pollCnt, pollCntNx;
    logic          progPoll, progPollNx, errFlag, errFlagNx, wdrQ;
    logic          ifEnableNx, busyNx, doneNx, errorNx, ackNx;
    logic [7:0]    fCommandNx, fDataWrNx, lastStatusNx;
    logic [23:0]   fAddressNx;

    always_ff @(posedge serialClk) begin
        if (!reset_n) begin
            state      <= IDLE;
            afterGap   <= IDLE;
            afterWren  <= IDLE;
            gapCnt     <= '0;
            count      <= '0;
            loaded     <= '0;
            sent       <= '0;
            pollCnt    <= '0;
            progPoll   <= 1'b0;
            errFlag    <= 1'b0;
            wdrQ       <= 1'b0;
            ifEnable_n <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            wrByteAck  <= 1'b0;
            fCommand   <= '0;
            fAddress   <= '0;
            fData_WR   <= '0;
            lastStatus <= '0;
        end else begin
            state      <= stateNx;
            afterGap   <= afterGapNx;
            afterWren  <= afterWrenNx;
            gapCnt     <= gapCntNx;
            count      <= countNx;
            loaded     <= loadedNx;
            sent       <= sentNx;
            pollCnt    <= pollCntNx;
            progPoll   <= progPollNx;
            errFlag    <= errFlagNx;
            wdrQ       <= WrDataReady;
            ifEnable_n <= ifEnableNx;
            busy       <= busyNx;
            done       <= doneNx;
            error      <= errorNx;
            wrByteAck  <= ackNx;
            fCommand   <= fCommandNx;
            fAddress   <= fAddressNx;
            fData_WR   <= fDataWrNx;
            lastStatus <= lastStatusNx;
        end
    end

    always_comb begin
        stateNx      = state;
        afterGapNx   = afterGap;
        afterWrenNx  = afterWren;
        gapCntNx     = gapCnt;
        countNx      = count;
        loadedNx     = loaded;
        sentNx       = sent;
        pollCntNx    = pollCnt;
        progPollNx   = progPoll;
        errFlagNx    = errFlag;
        ifEnableNx   = ifEnable_n;
        busyNx       = busy;
        doneNx       = 1'b0;
        errorNx      = 1'b0;
        ackNx        = 1'b0;
        fCommandNx   = fCommand;
        fAddressNx   = fAddress;
        fDataWrNx    = fData_WR;
        lastStatusNx = lastStatus;

        case (state)
            IDLE: begin
                if (start && !busy) begin
                    busyNx     = 1'b1;
                    errFlagNx  = 1'b0;
                    progPollNx = 1'b0;
                    countNx    = (byteCount > 9'd256) ? 9'd256 : byteCount;
                    fAddressNx = {pageAddr, 8'h00};
                    if (doErase) begin
                        stateNx     = WREN;
                        afterWrenNx = ERASE;
                    end else if (byteCount != 9'd0) begin
                        stateNx     = WREN;
                        afterWrenNx = PP_LOAD;
                    end else begin
                        stateNx = FINISH;
                    end
                end
            end
            WREN: begin
                if (cmdFinished) begin
                    ifEnableNx = 1'b1;
                    stateNx    = GAP;
                    gapCntNx   = '0;
                    afterGapNx = afterWren;
                end
            end
            ERASE: begin
                if (cmdFinished) begin
                    ifEnableNx = 1'b1;
                    stateNx    = GAP;
                    gapCntNx   = '0;
                    afterGapNx = POLL;
                end
            end
            POLL: begin
                if (cmdFinished) begin
                    lastStatusNx = fData_RD;
                    pollCntNx    = pollCnt + 24'd1;
                    if (!fData_RD[0]) begin
                        ifEnableNx  = 1'b1;
                        stateNx     = GAP;
                        gapCntNx    = '0;
                        afterWrenNx = PP_LOAD;
                        afterGapNx  = (progPoll || count == 9'd0) ? FINISH : WREN;
                    end else if (pollCnt + 24'd1 == POLL_LIMIT) begin
                        // Timeout skips the gap: the next command can only follow a new start.
                        ifEnableNx = 1'b1;
                        errFlagNx  = 1'b1;
                        stateNx    = FINISH;
                    end
                end
            end
            PP_LOAD: begin
                fDataWrNx = wrByte;
                stateNx   = PROGRAM;
            end
            PROGRAM: begin
                // The ack cycle is the one whose closing edge captures wrByte.
                if (wrByteAck)
                    fDataWrNx = wrByte;
                if (WrDataReady && !wdrQ && loaded < count) begin
                    ackNx    = 1'b1;
                    loadedNx = loaded + 9'd1;
                end
                if (cmdFinished) begin
                    sentNx = sent + 9'd1;
                    if (sent + 9'd1 == count) begin
                        ifEnableNx = 1'b1;
                        stateNx    = GAP;
                        gapCntNx   = '0;
                        afterGapNx = POLL;
                        progPollNx = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gapCnt == GAP_LAST)
                    stateNx = afterGap;
                else
                    gapCntNx = gapCnt + 1'b1;
            end
            FINISH: begin
                doneNx  = 1'b1;
                errorNx = errFlag;
                busyNx  = 1'b0;
                stateNx = IDLE;
            end
            default: stateNx = IDLE;
        endcase

        // Entry actions: drive the interface for the phase being entered.
        if (stateNx != state) begin
            case (stateNx)
                WREN: begin
                    ifEnableNx = 1'b0;
                    fCommandNx = 8'h06;
                end
                ERASE: begin
                    ifEnableNx = 1'b0;
                    fCommandNx = 8'h81;
                end
                POLL: begin
                    ifEnableNx = 1'b0;
                    fCommandNx = 8'h05;
                    pollCntNx  = '0;
                end
                PP_LOAD: begin
                    ackNx      = 1'b1;
                    loadedNx   = 9'd1;
                    fCommandNx = 8'h02;
                end
                PROGRAM: begin
                    ifEnableNx = 1'b0;
                    sentNx     = '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nano4k_flash_page_sequencer.sv
// Scoreboard bench: a page-update reference model queues expected commands, program bytes
// and completion records; a monitor and a flash-interface model compare what the DUT does.
module tb_nano4k_flash_page_sequencer;
    localparam int          CS_GAP = 4;
    localparam logic [23:0] LIMIT  = 24'd8;

    logic        serialClk = 1'b0;
    logic        reset_n = 1'b0, start = 1'b0, doErase = 1'b0;
    logic [15:0] pageAddr = '0;
    logic [8:0]  byteCount = '0;
    logic [7:0]  wrByte = '0, fData_RD = '0;
    logic        cmdFinished = 1'b0, WrDataReady = 1'b0;
    logic        wrByteAck, busy, done, error, ifEnable_n;
    logic [7:0]  lastStatus, fCommand, fData_WR;
    logic [23:0] fAddress;

    always #5 serialClk = ~serialClk;

    nano4k_flash_page_sequencer #(.CS_GAP(CS_GAP), .POLL_LIMIT(LIMIT)) dut (
        .serialClk(serialClk), .reset_n(reset_n), .start(start), .doErase(doErase),
        .pageAddr(pageAddr), .byteCount(byteCount), .wrByte(wrByte), .wrByteAck(wrByteAck),
        .busy(busy), .done(done), .error(error), .lastStatus(lastStatus),
        .ifEnable_n(ifEnable_n), .fCommand(fCommand), .fAddress(fAddress),
        .fData_WR(fData_WR), .fData_RD(fData_RD), .cmdFinished(cmdFinished),
        .WrDataReady(WrDataReady)
    );

    // kind 0 = command {cmd,addr}, 1 = program byte, 2 = completion {acks,error,lastStatus}
    typedef struct {
        int          kind;
        logic [31:0] val;
        bit          chkAddr;
    } ev_t;

    ev_t         expQ[$];
    logic [7:0]  statusQ[$];
    logic [7:0]  dataArr[256];
    int          checks = 0, failures = 0;
    int          doneCnt = 0, ackCnt = 0;
    bit          ignoreEvents = 1'b0;
    logic [7:0]  refLast = 8'h00;
    bit          prevEn = 1'b1;
    int          highRun = 0, cmdsInOp = 0;
    int          wIdx = 0;
    bit          wSeen = 1'b0;
    logic [7:0]  mCmd;
    int          abortDone, abortCyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkEvent(input int kind, input logic [31:0] val);
        ev_t e;
        logic [31:0] mask;
        if (ignoreEvents) return;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind %0d value %0h expected nothing", kind, val);
            return;
        end
        e = expQ.pop_front();
        mask = (kind == 0 && !e.chkAddr) ? 32'hFF00_0000 : 32'hFFFF_FFFF;
        if (e.kind != kind || ((val ^ e.val) & mask) != 32'd0) begin
            failures++;
            $display("FAIL event: got kind %0d value %0h expected kind %0d value %0h",
                     kind, val, e.kind, e.val);
        end
    endtask

    task automatic pushEv(input int k, input logic [31:0] v, input bit ca);
        ev_t e;
        e.kind = k; e.val = v; e.chkAddr = ca;
        expQ.push_back(e);
    endtask

    // One RDSR poll: consume status bytes until WIP clears or the limit is hit.
    task automatic refPoll(inout int si, inout bit err);
        int nb;
        logic [7:0] b;
        nb = 0;
        forever begin
            if (si < statusQ.size()) b = statusQ[si];
            else b = 8'h00;
            si++; nb++;
            refLast = b;
            if (!b[0]) break;
            if (nb == int'(LIMIT)) begin
                err = 1'b1;
                break;
            end
        end
    endtask

    task automatic refOp(input bit er, input logic [15:0] pg, input logic [8:0] bc);
        int n, si, acks;
        bit err;
        n = (bc > 9'd256) ? 256 : int'(bc);
        si = 0; err = 1'b0; acks = 0;
        if (er) begin
            pushEv(0, {8'h06, 24'h0}, 1'b0);
            pushEv(0, {8'h81, pg, 8'h00}, 1'b1);
            pushEv(0, {8'h05, 24'h0}, 1'b0);
            refPoll(si, err);
        end
        if (!err && n > 0) begin
            pushEv(0, {8'h06, 24'h0}, 1'b0);
            pushEv(0, {8'h02, pg, 8'h00}, 1'b1);
            for (int i = 0; i < n; i++) pushEv(1, {24'd0, dataArr[i]}, 1'b0);
            pushEv(0, {8'h05, 24'h0}, 1'b0);
            refPoll(si, err);
            acks = n;
        end
        pushEv(2, {14'd0, 9'(acks), err, refLast}, 1'b0);
    endtask

    // Monitor: command starts, chip-select gaps, acks and completion.
    initial begin
        forever begin
            @(negedge serialClk);
            if (prevEn && !ifEnable_n) begin
                if (cmdsInOp > 0) chk("cs_gap_min", {31'd0, highRun >= CS_GAP}, 32'd1);
                checkEvent(0, {fCommand, fAddress});
                cmdsInOp++;
            end
            highRun = ifEnable_n ? highRun + 1 : 0;
            prevEn = ifEnable_n;
            if (wrByteAck) ackCnt++;
            if (done) begin
                doneCnt++;
                checkEvent(2, {14'd0, ackCnt[8:0], error, lastStatus});
                ackCnt = 0;
                cmdsInOp = 0;
            end else if (!busy) begin
                ackCnt = 0;
                cmdsInOp = 0;
            end
        end
    end

    // Byte source: present dataArr[k] until the k-th ack has been consumed.
    initial begin
        forever begin
            @(negedge serialClk);
            if (!busy) begin
                wIdx = 0;
                wSeen = 1'b0;
            end else begin
                if (wSeen) wIdx++;
                wSeen = wrByteAck;
            end
            wrByte = (wIdx < 256) ? dataArr[wIdx] : 8'hEE;
        end
    end

    // Flash interface model: one cmdFinished per byte while enabled; MOSI bytes are checked.
    initial begin
        forever begin
            @(negedge serialClk);
            if (reset_n && !ifEnable_n) begin
                mCmd = fCommand;
                while (!ifEnable_n) begin
                    repeat ($urandom_range(1, 2)) @(negedge serialClk);
                    if (ifEnable_n) break;
                    if (mCmd == 8'h05) begin
                        if (statusQ.size() > 0) fData_RD = statusQ.pop_front();
                        else fData_RD = 8'h00;
                    end
                    if (mCmd == 8'h02) begin
                        checkEvent(1, {24'd0, fData_WR});
                        WrDataReady = 1'b1;
                        @(negedge serialClk);
                        WrDataReady = 1'b0;
                        @(negedge serialClk);
                        @(negedge serialClk);
                        if (ifEnable_n) break;
                    end
                    cmdFinished = 1'b1;
                    @(negedge serialClk);
                    cmdFinished = 1'b0;
                end
            end
        end
    end

    task automatic fillData();
        for (int i = 0; i < 256; i++) dataArr[i] = 8'($urandom);
    endtask

    task automatic pushPoll(input int wipBytes);
        logic [7:0] r;
        for (int i = 0; i < wipBytes; i++) begin
            r = 8'($urandom);
            statusQ.push_back({r[7:1], 1'b1});
        end
        r = 8'($urandom);
        statusQ.push_back({r[7:1], 1'b0});
    endtask

    task automatic runOp(input bit er, input logic [15:0] pg, input logic [8:0] bc, input bit poke);
        int startDone, cyc;
        logic [31:0] r;
        refOp(er, pg, bc);
        startDone = doneCnt;
        doErase = er; pageAddr = pg; byteCount = bc; start = 1'b1;
        @(negedge serialClk);
        r = $urandom;
        start = 1'b0; doErase = r[0]; pageAddr = r[31:16]; byteCount = r[8:0];
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        cyc = 0;
        while (doneCnt == startDone && cyc < 20000) begin
            @(negedge serialClk);
            cyc++;
            start = poke && cyc == 6 && busy && doneCnt == startDone;
        end
        start = 1'b0;
        if (doneCnt == startDone) begin
            checks++; failures++;
            $display("FAIL done_timeout: got no done within %0d cycles expected done", cyc);
            reset_n = 1'b0;
            repeat (2) @(negedge serialClk);
            reset_n = 1'b1;
            expQ.delete();
            refLast = 8'h00;
        end
        chk("queue_drain", 32'(expQ.size()), 32'd0);
        repeat (6) @(negedge serialClk);
    endtask

    initial begin
        logic [31:0] r;
        logic [8:0]  bc;
        @(posedge serialClk);
        #1;
        chk("rst_first_edge_ifEnable_n", {31'd0, ifEnable_n}, 32'd1);
        repeat (2) @(negedge serialClk);
        chk("rst_busy_done_err_ack", {28'd0, busy, done, error, wrByteAck}, 32'd0);
        chk("rst_cmd_addr", {fCommand, fAddress}, 32'd0);
        chk("rst_data_status", {16'd0, fData_WR, lastStatus}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge serialClk);

        // Erase only, WIP for three status bytes.
        fillData(); statusQ.delete();
        statusQ.push_back(8'h03); statusQ.push_back(8'h01);
        statusQ.push_back(8'h83); statusQ.push_back(8'h00);
        runOp(1'b1, 16'h0012, 9'd0, 1'b0);

        // Four-byte program, with a start poked mid-operation.
        fillData(); statusQ.delete();
        dataArr[0] = 8'hA1; dataArr[1] = 8'hA2; dataArr[2] = 8'hA3; dataArr[3] = 8'hA4;
        pushPoll(2);
        runOp(1'b0, 16'h3456, 9'd4, 1'b1);

        // Clamp to 256 bytes on the top page.
        fillData(); statusQ.delete(); pushPoll(0);
        runOp(1'b0, 16'hFFFF, 9'd300, 1'b0);

        // Program poll stuck busy, then erase poll stuck busy.
        fillData(); statusQ.delete();
        for (int i = 0; i < 12; i++) statusQ.push_back(8'h01);
        runOp(1'b0, 16'h0100, 9'd2, 1'b0);
        fillData(); statusQ.delete();
        for (int i = 0; i < 10; i++) statusQ.push_back(8'h01);
        runOp(1'b1, 16'h0200, 9'd5, 1'b0);

        // Nothing to do, and single-byte program.
        runOp(1'b0, 16'h0300, 9'd0, 1'b0);
        fillData(); statusQ.delete(); pushPoll(1);
        runOp(1'b0, 16'h0400, 9'd1, 1'b0);

        // Reset during programming, then a clean operation.
        fillData(); statusQ.delete();
        ignoreEvents = 1'b1;
        abortDone = doneCnt;
        doErase = 1'b0; pageAddr = 16'h0555; byteCount = 9'd10; start = 1'b1;
        @(negedge serialClk);
        start = 1'b0;
        abortCyc = 0;
        while (ackCnt < 2 && abortCyc < 2000) begin
            @(negedge serialClk);
            abortCyc++;
        end
        chk("abort_reached_byte2", {31'd0, ackCnt >= 2}, 32'd1);
        reset_n = 1'b0;
        @(posedge serialClk);
        #1;
        chk("abort_ifEnable_n", {31'd0, ifEnable_n}, 32'd1);
        chk("abort_busy_ack", {30'd0, busy, wrByteAck}, 32'd0);
        chk("abort_fCommand", {24'd0, fCommand}, 32'd0);
        repeat (2) @(negedge serialClk);
        reset_n = 1'b1;
        repeat (10) @(negedge serialClk);
        chk("abort_no_done", 32'(doneCnt), 32'(abortDone));
        ignoreEvents = 1'b0;
        expQ.delete();
        refLast = 8'h00;
        fillData(); statusQ.delete(); pushPoll(1);
        runOp(1'b0, 16'h0555, 9'd3, 1'b0);

        // Randomized operations.
        for (int t = 0; t < 16; t++) begin
            r = $urandom;
            case (r[3:0] % 10)
                0:       bc = 9'd0;
                1:       bc = 9'(256 + $urandom_range(1, 255));
                2:       bc = 9'd256;
                3:       bc = 9'd1;
                default: bc = 9'($urandom_range(2, 24));
            endcase
            fillData(); statusQ.delete();
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 7) == 0)
                    for (int i = 0; i < int'(LIMIT) + 2; i++) statusQ.push_back(8'h01);
                else
                    pushPoll($urandom_range(0, 4));
            end
            runOp(r[4], r[31:16], bc, r[5]);
        end

        chk("final_queue_empty", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
